// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: applies new divider ratios only at period boundaries via a req/ack handshake.
// Define CLK_DIV_CTRL_SETTLE_EN to hold off the ack for SETTLE_PERIODS divided periods after apply.
module clk_div_ctrl #(
    parameter int N              = 4,
    parameter int DIV_RESET      = 4,
    parameter int SETTLE_PERIODS = 8
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         cfg_req,
    input  logic [N-1:0] cfg_div,
    output logic         cfg_ack,
    output logic         cfg_err,
    output logic         busy,
    output logic [N-1:0] divider,
    output logic         period_tick
);
    localparam logic [N-1:0] ONE = N'(1);

    if (DIV_RESET < 1 || SETTLE_PERIODS < 1) begin : g_bad_cfg
        $error("clk_div_ctrl: DIV_RESET and SETTLE_PERIODS must be >= 1");
    end

`ifdef CLK_DIV_CTRL_SETTLE_EN
    typedef enum logic [2:0] {IDLE, WAIT_WRAP, SETTLE, DONE, RELEASE} state_t;
    localparam int SW = $clog2(SETTLE_PERIODS + 1);
    logic [SW-1:0] settle_cnt;
`else
    typedef enum logic [2:0] {IDLE, WAIT_WRAP, DONE, RELEASE} state_t;
`endif

    state_t       state;
    logic [N-1:0] shadow;
    logic [N-1:0] pending;
    logic         wrap;

    // shadow tracks the divider's own counter, so the divider must leave reset together with this block
    assign wrap        = shadow >= divider - ONE;
    assign period_tick = wrap;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            divider <= N'(DIV_RESET);
            shadow  <= '0;
            pending <= '0;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            busy    <= 1'b0;
`ifdef CLK_DIV_CTRL_SETTLE_EN
            settle_cnt <= '0;
`endif
        end else begin
            shadow  <= wrap ? '0 : shadow + ONE;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: if (cfg_req) begin
                    busy <= 1'b1;
                    if (cfg_div == '0) begin
                        state   <= DONE;
                        cfg_ack <= 1'b1;
                        cfg_err <= 1'b1;
                    end else begin
                        pending <= cfg_div;
                        state   <= WAIT_WRAP;
                    end
                end
                // the divider restarts its count on this same edge, so no runt period
                WAIT_WRAP: if (wrap) begin
                    divider <= pending;
`ifdef CLK_DIV_CTRL_SETTLE_EN
                    settle_cnt <= '0;
                    state      <= SETTLE;
`else
                    state   <= DONE;
                    cfg_ack <= 1'b1;
`endif
                end
`ifdef CLK_DIV_CTRL_SETTLE_EN
                SETTLE: if (wrap) begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_cnt == SW'(SETTLE_PERIODS - 1)) begin
                        state   <= DONE;
                        cfg_ack <= 1'b1;
                    end
                end
`endif
                DONE: state <= RELEASE;
                RELEASE: if (!cfg_req) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Ratio-update controller for the integer clock divider. It owns the divider's `divider[N-1:0]` input. It accepts new ratios from a requester over a req/ack handshake and applies each ratio only at a divided-clock period boundary, so the divider output never produces a runt pulse. It then optionally holds off the acknowledge for a settle interval, giving the PLL feedback path time to re-lock.

## Interface
Parameters:
- `N`, 4: divider ratio width; must match the divider instance.
- `DIV_RESET`, 4: ratio driven on `divider` out of reset; must be ≥1.
- `SETTLE_PERIODS`, 8: number of divided-clock periods waited after applying a ratio (used only with `CLK_DIV_CTRL_SETTLE_EN`); must be ≥1.

Ports:
- `clk_in`, input, 1: clock; the same clock that drives the divider.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cfg_req`, input, 1: level request; hold high with `cfg_div` stable until `cfg_ack`.
- `cfg_div`, input, N: requested ratio.
- `cfg_ack`, output, 1: one-cycle pulse when the request completes.
- `cfg_err`, output, 1: one-cycle pulse coincident with `cfg_ack` when the request is rejected.
- `busy`, output, 1: high in every state except IDLE.
- `divider`, output, N: ratio fed to the divider; registered.
- `period_tick`, output, 1: one-cycle pulse on each divider counter wrap.

## Operation
- **Shadow counter.** `shadow` (N bits) mirrors the divider's internal counter.
  - Each `clk_in` edge: `shadow <= (shadow >= divider-1) ? 0 : shadow+1`. Arithmetic is N-bit unsigned.
  - `wrap = (shadow >= divider-1)`; `period_tick = wrap` (combinational from registers).
  - With `divider == 1`, `wrap` is high every cycle.
- **FSM states:** IDLE, WAIT_WRAP, SETTLE, DONE, RELEASE.
- **IDLE**
  - If `cfg_req` is high and `cfg_div == 0`: go to DONE with the error flag set. `divider` is unchanged.
  - Else if `cfg_req` is high: capture `pending <= cfg_div` and go to WAIT_WRAP.
- **WAIT_WRAP**
  - On the edge where `wrap` is high: `divider <= pending` and `shadow <= 0`, the same edge at which the divider's counter restarts.
  - Then go to SETTLE if the macro is defined, otherwise to DONE.
  - A request whose ratio equals the current ratio still waits for a wrap.
- **SETTLE**
  - `settle_cnt` is cleared on entry and increments on each `wrap`.
  - When it reaches `SETTLE_PERIODS`, go to DONE.
- **DONE**
  - Assert `cfg_ack` for exactly one cycle.
  - Assert `cfg_err` in the same cycle if the request was rejected.
  - Then go to RELEASE.
- **RELEASE**
  - Wait for `cfg_req` low, then go to IDLE.
  - A request held high after `cfg_ack` is never re-captured.
- **Mid-operation request changes.** Changes to `cfg_req` or `cfg_div` while `busy` is high are ignored (captured value wins). Deasserting `cfg_req` before `cfg_ack` does not abort the operation.

## Timing
- **Reset values** (asynchronous on `rst_n` low): `divider = DIV_RESET`, `shadow = 0`, `pending = 0`, `settle_cnt = 0`, state IDLE, `cfg_ack = 0`, `cfg_err = 0`, `busy = 0`.
  - Reset mid-operation discards the pending request; no ack is issued.
  - The divider's own counter must be aligned to the shadow counter at reset release: hold the divider off until release or reset it from the same source.
- **Request capture:** edge 0 (IDLE, `cfg_req` high); `busy` is high from cycle 1.
- **Apply latency:** 1 to old-ratio cycles after capture. `divider` changes on the first wrap edge after entering WAIT_WRAP.
- **Ack, macro absent:** `cfg_ack` is high in the cycle after the apply edge.
- **Ack, macro present:** `cfg_ack` is high in the cycle after the `SETTLE_PERIODS`-th wrap under the new ratio, i.e. `SETTLE_PERIODS × new_ratio` cycles after apply, +1.
- **Rejected ratio:** `cfg_ack` and `cfg_err` are high 1 cycle after capture.
- **Re-request:** at least one cycle with `cfg_req` low between acks; minimum handshake turnaround is 2 cycles after ack.

## Configuration
- Macro: `CLK_DIV_CTRL_SETTLE_EN`.
- **Defined:** the SETTLE state and a `settle_cnt` of width `$clog2(SETTLE_PERIODS+1)` are built; ack is delayed as described under Timing.
- **Undefined:** SETTLE and `settle_cnt` are absent; WAIT_WRAP goes directly to DONE; `SETTLE_PERIODS` is ignored.

## Test plan
- Reset with `DIV_RESET=4` → `divider=4`, `period_tick` every 4 cycles, `cfg_ack=0`, `busy=0`.
- Request `cfg_div=6` while shadow is 1 → `divider` switches on the edge where shadow is 3; `period_tick` spacing goes 4 → 6. Ack timing: macro off, 1 cycle later; macro on with `SETTLE_PERIODS=8`, after 48 cycles +1.
- Request `cfg_div=0` → `cfg_ack` and `cfg_err` pulse 1 cycle after capture; `divider` unchanged.
- Request `cfg_div=1` from ratio 3 → `period_tick` is high every cycle after apply; ack per mode.
- Hold `cfg_req` high for 20 cycles after ack with a new `cfg_div` → no capture; drop then raise `cfg_req` → new capture.
- Assert `rst_n` low while in WAIT_WRAP → `divider` returns to `DIV_RESET`, no `cfg_ack`, `busy=0`.
